// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one aligned read at a time to
// instruction memory and presents each returned word with its PC to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        next_valid,
  output logic [31:0] next_inst,
  output logic [31:0] next_pc,
  input  logic        decode_ready
);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        next_valid_q, next_valid_d;
  logic [31:0] next_inst_q, next_inst_d;
  logic [31:0] next_pc_q, next_pc_d;

  logic slot_free;
  logic req_fire;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign slot_free      = !next_valid_q || decode_ready;
  assign imem_req_valid = !rst && (state_q == S_REQ) && slot_free && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign next_valid = next_valid_q;
  assign next_inst  = next_inst_q;
  assign next_pc    = next_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    next_valid_d = next_valid_q;
    next_inst_d  = next_inst_q;
    next_pc_d    = next_pc_q;

    if (redirect_valid) begin
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      next_valid_d = 1'b0;
      next_inst_d  = NOP_INST;
      // A response landing with the redirect is simply discarded; otherwise
      // the still-outstanding response must be dropped when it returns.
      if (state_q == S_WAIT) begin
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = S_REQ;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else begin
      if (next_valid_q && decode_ready) begin
        next_valid_d = 1'b0;
        next_inst_d  = NOP_INST;
      end
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              next_valid_d = 1'b1;
              next_inst_d  = imem_rsp_data;
              next_pc_d    = req_pc_q;
            end
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      drop_q       <= 1'b0;
      next_valid_q <= 1'b0;
      next_inst_q  <= NOP_INST;
      next_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      next_valid_q <= next_valid_d;
      next_inst_q  <= next_inst_d;
      next_pc_q    <= next_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table against a latency-programmable
// memory model, plus a second instance exercising PC wrap-around.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic        rst, req_valid, req_ready, rsp_valid;
  logic [31:0] req_addr, rsp_data;
  logic        redir, dec_rdy, nvalid;
  logic [31:0] redir_pc, ninst, npc;

  // wrap-around instance signals
  logic        rst2, req_valid2, rsp_valid2, nvalid2;
  logic [31:0] req_addr2, rsp_data2, ninst2, npc2, mem2_addr;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .next_valid(nvalid), .next_inst(ninst), .next_pc(npc),
    .decode_ready(dec_rdy)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_INST(NOP)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_req_addr(req_addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .next_valid(nvalid2), .next_inst(ninst2), .next_pc(npc2),
    .decode_ready(1'b1)
  );

  // memory for the main instance: response mem_k cycles after acceptance
  int          mem_k;
  int          mem_wait;
  logic        mem_pend;
  logic [31:0] mem_addr;
  assign rsp_valid = mem_pend && (mem_wait == 0);
  assign rsp_data  = rsp_valid ? w(mem_addr) : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
    end else begin
      if (rsp_valid) mem_pend <= 1'b0;
      else if (mem_pend) mem_wait <= mem_wait - 1;
      if (req_valid && req_ready) begin
        mem_pend <= 1'b1;
        mem_addr <= req_addr;
        mem_wait <= mem_k - 1;
      end
    end
  end

  // memory for the wrap instance: fixed one-cycle latency
  always @(posedge clk) begin
    if (rst2) rsp_valid2 <= 1'b0;
    else      rsp_valid2 <= req_valid2;
    mem2_addr <= req_addr2;
  end
  assign rsp_data2 = w(mem2_addr);

  typedef struct {
    logic        rst, dec, redir;
    logic [31:0] rpc;
    int          k;
    logic        rv;
    logic [31:0] addr;
    logic        nv;
    logic [31:0] npc;
    logic [31:0] inst;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic d, input logic rd, input logic [31:0] rp,
                              input int k, input logic rv, input logic [31:0] a, input logic nv,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t v;
    v.rst = r; v.dec = d; v.redir = rd; v.rpc = rp; v.k = k;
    v.rv = rv; v.addr = a; v.nv = nv; v.npc = p; v.inst = ins;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst dec red rpc        k  rv addr        nv npc        inst
    vecs[0]  = mk(1, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[1]  = mk(0, 1, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     NOP);
    vecs[2]  = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[3]  = mk(0, 1, 0, 32'h0,     1, 1, 32'h4,     1, 32'h0,     w(32'h0));
    vecs[4]  = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[5]  = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,     w(32'h4));
    vecs[6]  = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,     w(32'h4));
    vecs[7]  = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,     w(32'h4));
    vecs[8]  = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,     w(32'h4));
    vecs[9]  = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h4,     w(32'h4));
    vecs[10] = mk(0, 1, 0, 32'h0,     3, 1, 32'h8,     1, 32'h4,     w(32'h4));
    vecs[11] = mk(0, 1, 1, 32'h102,   1, 0, 32'h0,     0, 32'h4,     NOP);
    vecs[12] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h4,     NOP);
    vecs[13] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h4,     NOP);
    vecs[14] = mk(0, 1, 0, 32'h0,     1, 1, 32'h100,   0, 32'h4,     NOP);
    vecs[15] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h4,     NOP);
    vecs[16] = mk(0, 1, 0, 32'h0,     1, 1, 32'h104,   1, 32'h100,   w(32'h100));
    vecs[17] = mk(0, 1, 1, 32'h200,   1, 0, 32'h0,     0, 32'h100,   NOP);
    vecs[18] = mk(0, 1, 0, 32'h0,     1, 1, 32'h200,   0, 32'h100,   NOP);
    vecs[19] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h100,   NOP);
    vecs[20] = mk(0, 1, 1, 32'h300,   1, 0, 32'h0,     1, 32'h200,   w(32'h200));
    vecs[21] = mk(0, 1, 0, 32'h0,     1, 1, 32'h300,   0, 32'h200,   NOP);
    vecs[22] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h200,   NOP);
    vecs[23] = mk(0, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h300,   w(32'h300));
    vecs[24] = mk(1, 0, 0, 32'h0,     1, 0, 32'h0,     1, 32'h300,   w(32'h300));
    vecs[25] = mk(0, 1, 0, 32'h0,     3, 1, 32'h0,     0, 32'h0,     NOP);
    vecs[26] = mk(0, 1, 0, 32'h0,     3, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[27] = mk(1, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[28] = mk(0, 1, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     NOP);
    vecs[29] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[30] = mk(0, 1, 0, 32'h0,     3, 1, 32'h4,     1, 32'h0,     w(32'h0));
    vecs[31] = mk(0, 1, 1, 32'h400,   1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[32] = mk(0, 1, 1, 32'h503,   1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[33] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[34] = mk(0, 1, 0, 32'h0,     1, 1, 32'h500,   0, 32'h0,     NOP);
    vecs[35] = mk(0, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     NOP);
    vecs[36] = mk(0, 1, 0, 32'h0,     1, 1, 32'h504,   1, 32'h500,   w(32'h500));

    rst = 1'b1; rst2 = 1'b1; req_ready = 1'b1; dec_rdy = 1'b1;
    redir = 1'b0; redir_pc = 32'h0; mem_k = 1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst      = vecs[i].rst;
      dec_rdy  = vecs[i].dec;
      redir    = vecs[i].redir;
      redir_pc = vecs[i].rpc;
      mem_k    = vecs[i].k;
      #2;
      chk("req_valid", i, {31'h0, req_valid}, {31'h0, vecs[i].rv});
      if (vecs[i].rv) chk("req_addr", i, req_addr, vecs[i].addr);
      chk("next_valid", i, {31'h0, nvalid}, {31'h0, vecs[i].nv});
      chk("next_pc", i, npc, vecs[i].npc);
      chk("next_inst", i, ninst, vecs[i].inst);
      step();
    end
    redir = 1'b0;

    // PC wrap from 0xFFFF_FFFC to 0 on the second instance
    step();
    rst2 = 1'b0;
    #2;
    chk("wrap_rv1", 1, {31'h0, req_valid2}, 32'h1);
    chk("wrap_addr1", 1, req_addr2, 32'hFFFF_FFF8);
    step();
    chk("wrap_rv2", 2, {31'h0, req_valid2}, 32'h0);
    step();
    chk("wrap_addr3", 3, req_addr2, 32'hFFFF_FFFC);
    chk("wrap_nv3", 3, {31'h0, nvalid2}, 32'h1);
    chk("wrap_npc3", 3, npc2, 32'hFFFF_FFF8);
    chk("wrap_inst3", 3, ninst2, w(32'hFFFF_FFF8));
    step(); step();
    chk("wrap_rv5", 5, {31'h0, req_valid2}, 32'h1);
    chk("wrap_addr5", 5, req_addr2, 32'h0000_0000);
    chk("wrap_npc5", 5, npc2, 32'hFFFF_FFFC);
    step(); step();
    chk("wrap_npc7", 7, npc2, 32'h0000_0000);
    chk("wrap_inst7", 7, ninst2, w(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
